// File: rtl/leds_show_pkg.sv
// leds_show_pkg: shared types and constants for the single-LED show controller.
// Holds the display-mode encoding, the mode count and the debounce counter width.
package leds_show_pkg;

    localparam int DEBOUNCE_CNT_W = 16;
    localparam int MODE_COUNT     = 4;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ON   = 2'd1,
        SLOW = 2'd2,
        FAST = 2'd3
    } led_mode_t;

    // Cycle OFF -> ON -> SLOW -> FAST -> OFF
    function automatic led_mode_t next_mode(input led_mode_t m);
        if (m == led_mode_t'(2'(MODE_COUNT - 1))) begin
            return OFF;
        end
        return led_mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/leds_show_button_debouncer.sv
// button_debouncer: 2-FF synchronizer, debounce counter and press (rising-edge) detect
// for a raw asynchronous push button.
module button_debouncer
    import leds_show_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                      sync1;
    logic                      sync2;
    logic                      db;
    logic                      db_q;
    logic [DEBOUNCE_CNT_W-1:0] cnt;

    // Two-flop synchronizer bringing the raw pin into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed from db for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (sync2 == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            db  <= ~db;
        end else begin
            cnt <= cnt + DEBOUNCE_CNT_W'(1);
        end
    end

    // One-cycle delayed copy of the debounced level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= 1'b0;
        end else begin
            db_q <= db;
        end
    end

    assign btn_db = db;
    assign press  = db & ~db_q;

endmodule

// File: rtl/leds_show.sv
// leds_show: single-LED show controller. Each debounced button press advances the
// display mode. Optional macro LEDS_SHOW_BLINK_EN enables the four-mode version
// (OFF/ON/SLOW/FAST with blink generator); without it each press toggles OFF/ON.
module leds_show
    import leds_show_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BLINK_SLOW_DIV  = 8,
    parameter int BLINK_FAST_DIV  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pushButton,
    output logic led
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("leds_show: DEBOUNCE_CYCLES out of range");
    end
    if (BLINK_SLOW_DIV < 2 || BLINK_FAST_DIV < 1 || BLINK_FAST_DIV >= BLINK_SLOW_DIV) begin : g_bad_blink
        $error("leds_show: illegal BLINK_SLOW_DIV / BLINK_FAST_DIV combination");
    end

    logic btn_db;
    logic press;
    logic step;
    logic led_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(pushButton),
        .btn_db (btn_db),
        .press  (press)
    );

    // press already implies the debounced level is high; the AND only makes that explicit
    assign step = press & btn_db;

`ifdef LEDS_SHOW_BLINK_EN

    localparam int BLINK_CNT_W = $clog2(BLINK_SLOW_DIV);
    localparam logic [BLINK_CNT_W-1:0] SLOW_LAST = BLINK_CNT_W'(BLINK_SLOW_DIV - 1);
    localparam logic [BLINK_CNT_W-1:0] FAST_LAST = BLINK_CNT_W'(BLINK_FAST_DIV - 1);

    led_mode_t              mode;
    led_mode_t              mode_next;
    logic [BLINK_CNT_W-1:0] blink_cnt;
    logic [BLINK_CNT_W-1:0] blink_last;
    logic                   phase;

    // Mode state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= OFF;
        end else begin
            mode <= mode_next;
        end
    end

    // Next mode: advance once per accepted press
    always_comb begin
        mode_next = mode;
        if (step) begin
            mode_next = next_mode(mode);
        end
    end

    assign blink_last = (mode == SLOW) ? SLOW_LAST : FAST_LAST;

    // Blink generator: restart lit on every mode change, toggle phase every div cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (step) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (mode == SLOW || mode == FAST) begin
            if (blink_cnt == blink_last) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_CNT_W'(1);
            end
        end else begin
            blink_cnt <= '0;
        end
    end

    // LED drive decoded from the current mode
    always_comb begin
        led_d = 1'b0;
        case (mode)
            OFF:     led_d = 1'b0;
            ON:      led_d = 1'b1;
            SLOW:    led_d = phase;
            FAST:    led_d = phase;
            default: led_d = 1'b0;
        endcase
    end

`else

    logic mode_on;
    logic mode_on_next;

    // Mode state register (OFF/ON only)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_on <= 1'b0;
        end else begin
            mode_on <= mode_on_next;
        end
    end

    // Next mode: each press toggles OFF <-> ON
    always_comb begin
        mode_on_next = mode_on;
        if (step) begin
            mode_on_next = ~mode_on;
        end
    end

    // LED drive follows the mode directly
    always_comb begin
        led_d = mode_on;
    end

`endif

    // Registered LED output so nothing from the button reaches the pin combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= 1'b0;
        end else begin
            led <= led_d;
        end
    end

endmodule

// File: tb/tb_leds_show.sv
// tb_leds_show: directed, table-driven bench for leds_show with default parameters.
// Expectations follow LEDS_SHOW_BLINK_EN: four-mode cycle when defined, OFF/ON toggle otherwise.
module tb_leds_show;

    typedef struct {
        int   hold;
        bit   chk7;
        logic exp7;
        int   div;
        logic steady;
    } vec_t;

    localparam int WINDOW = 40;

    logic clk;
    logic rst_n;
    logic push_button;
    logic led;

    int assert_count;
    int fail_count;

    vec_t vecs[4];

    leds_show #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_SLOW_DIV (8),
        .BLINK_FAST_DIV (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pushButton(push_button),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: led=%b expected %b", name, actual, expected);
        end
    endtask

    // Drive the button, let one rising edge sample it, then settle 1 time unit
    task automatic tickWith(input logic btn);
        push_button = btn;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int hold, input int total);
        for (int e = 1; e <= total; e++) begin
            tickWith(e <= hold);
        end
    endtask

    initial begin
        logic exp;
        int   j;

        assert_count = 0;
        fail_count   = 0;
        rst_n        = 1'b0;
        push_button  = 1'b0;

`ifdef LEDS_SHOW_BLINK_EN
        vecs[0] = '{hold: 10, chk7: 1'b1, exp7: 1'b0, div: 0, steady: 1'b1};
        vecs[1] = '{hold: 12, chk7: 1'b1, exp7: 1'b1, div: 8, steady: 1'b0};
        vecs[2] = '{hold: 10, chk7: 1'b0, exp7: 1'b0, div: 2, steady: 1'b0};
        vecs[3] = '{hold: 4,  chk7: 1'b0, exp7: 1'b0, div: 0, steady: 1'b0};
        $display("[TB] build with LEDS_SHOW_BLINK_EN");
`else
        vecs[0] = '{hold: 10, chk7: 1'b1, exp7: 1'b0, div: 0, steady: 1'b1};
        vecs[1] = '{hold: 12, chk7: 1'b1, exp7: 1'b1, div: 0, steady: 1'b0};
        vecs[2] = '{hold: 10, chk7: 1'b1, exp7: 1'b0, div: 0, steady: 1'b1};
        vecs[3] = '{hold: 4,  chk7: 1'b1, exp7: 1'b1, div: 0, steady: 1'b0};
        $display("[TB] build without LEDS_SHOW_BLINK_EN");
`endif

        // Reset held while the button toggles
        for (int i = 0; i < 10; i++) begin
            tickWith(1'(i % 2));
            checkOutput($sformatf("reset_hold[%0d]", i), led, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tickWith(1'b0);
            checkOutput($sformatf("post_reset_idle[%0d]", i), led, 1'b0);
        end

        // Glitch shorter than the debounce window
        for (int i = 0; i < 23; i++) begin
            tickWith(i < 3);
            checkOutput($sformatf("glitch[%0d]", i), led, 1'b0);
        end

        // Table of presses: mode sequence, latency and blink waveform
        for (int v = 0; v < 4; v++) begin
            for (int e = 1; e < 8 + WINDOW; e++) begin
                tickWith(e <= vecs[v].hold);
                if (e == 7 && vecs[v].chk7) begin
                    checkOutput($sformatf("vec%0d_edge7", v), led, vecs[v].exp7);
                end
                if (e >= 8) begin
                    j = e - 8;
                    if (vecs[v].div == 0) begin
                        exp = vecs[v].steady;
                    end else begin
                        exp = ((j / vecs[v].div) % 2) == 0;
                    end
                    checkOutput($sformatf("vec%0d_edge%0d", v, e), led, exp);
                end
            end
        end

        // Reset while the LED is lit (FAST when blinking is built, ON otherwise)
`ifdef LEDS_SHOW_BLINK_EN
        applyStimulus(10, 48);
        applyStimulus(10, 48);
`endif
        applyStimulus(10, 8);
        checkOutput("lit_before_reset", led, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", led, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tickWith(1'b0);
            checkOutput($sformatf("reset_low[%0d]", i), led, 1'b0);
        end
        rst_n = 1'b1;
        applyStimulus(0, 5);
        checkOutput("idle_after_reset", led, 1'b0);
        applyStimulus(10, 7);
        checkOutput("press_after_reset_edge7", led, 1'b0);
        applyStimulus(3, 1);
        checkOutput("press_after_reset_edge8", led, 1'b1);
        applyStimulus(2, 20);
        checkOutput("on_steady_after_reset", led, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/leds_show.md
# leds_show

Single-LED show controller driven by one push button. It synchronizes and debounces the button. Each debounced press advances a display mode: off, steady on, slow blink, fast blink. It sits at the board top level between the raw `pushButton` pin and the `led` pin.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synced samples needed to accept a level change; legal range 1..2^16-1.
- `BLINK_SLOW_DIV`, default 8: clock cycles per LED half-period in slow blink; must be at least 2.
- `BLINK_FAST_DIV`, default 2: clock cycles per LED half-period in fast blink; must be at least 1 and less than `BLINK_SLOW_DIV`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `pushButton`  input  1  raw, asynchronous button level; 1 = pressed.
- `led`  output  1  registered LED drive; 1 = lit.

## Operation
- 2-FF synchronizer on `pushButton` (`sync1`, then `sync2`).
- Debouncer: counter increments while `sync2` != debounced level and clears when they are equal. When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears. Pulses shorter than `DEBOUNCE_CYCLES` synced cycles are ignored.
- Press = rising edge of the debounced level: `db & ~db_q`, where `db_q` is `db` delayed one cycle. A release (falling edge) has no effect.
- Mode FSM, 2-bit, advances once per press: OFF(0) -> ON(1) -> SLOW(2) -> FAST(3) -> OFF.
- Blink counter:
  - Clears and sets the blink phase to 1 on every mode change.
  - Otherwise counts up to div-1 of the current mode, then wraps to 0 and toggles the phase.
  - Held at 0 in OFF and ON.
- Registered LED output: `led` <= 0 in OFF, 1 in ON, blink phase in SLOW/FAST.
- Reset state: `led`=0, mode=OFF, `sync1`/`sync2`/`db`/`db_q`=0, all counters 0, phase=1.
- A button held through reset release counts as one press once debounced, since `db` resets to 0.
- Asserting reset mid-debounce or mid-blink returns every register to its reset state immediately.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples a new stable `pushButton` level.
  - `sync2` updates at edge 2.
  - `db` flips at edge 2+`DEBOUNCE_CYCLES`.
  - Mode updates at edge 3+`DEBOUNCE_CYCLES`.
  - `led` reflects the new mode at edge 4+`DEBOUNCE_CYCLES`. With the default of 4, that is edge 8.
- Blink half-periods are exact: `led` holds each level for exactly div cycles.
- On entering SLOW/FAST, `led` is 1 for the first div cycles.
- There is no combinational path from `pushButton` to `led`.

## Configuration
- `LEDS_SHOW_BLINK_EN` defined:
  - Four-mode FSM as described above.
  - Blink counter and phase logic present.
- `LEDS_SHOW_BLINK_EN` undefined:
  - Mode is 1 bit and each press toggles OFF <-> ON.
  - Blink counter and phase logic are not synthesized.
  - `BLINK_*` parameters are accepted but unused.
  - Debounce and latency are unchanged.

## Structure
- Package `leds_show_pkg` holds:
  - the `led_mode_t` enum (OFF, ON, SLOW, FAST) with fixed encodings 0..3;
  - the `MODE_COUNT` constant;
  - the `DEBOUNCE_CNT_W` constant (16) for the counter width.
- Sub-module `button_debouncer` (params `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `btn_raw`, `btn_db`, `press`) contains the synchronizer, the debounce counter and the edge detect.
- The top level holds the mode FSM, the blink generator and the `led` register.

## Test plan
All scenarios use the defaults: `DEBOUNCE_CYCLES`=4, SLOW=8, FAST=2.
- Reset: assert `rst_n`=0 with the button toggling -> `led`=0 throughout. After release with the button at 0, `led` stays 0 for 50 cycles.
- Glitch reject: `pushButton` high for 3 cycles, then low -> `led` stays 0 and mode stays OFF.
- Single press: `pushButton` high for 10 cycles -> `led`=1 exactly at edge 8 after the rise. Releasing does not change `led`.
- Slow blink: second press -> `led` toggles with a period of 16 cycles (8 high, 8 low), starting high.
- Fast blink, then wrap: third press -> `led` toggles with a period of 4 (2 high, 2 low). Fourth press -> `led`=0 steady.
- Reset mid-blink: drop `rst_n` during FAST -> `led`=0 asynchronously. Next press after release -> ON. With the macro undefined, the presses give 0 -> 1 -> 0 -> 1.
